// File: rtl/scan_code_pkg.sv
// Shared types and constants for the scan-code sequencer.
// Macro SCAN_CODE_EXT_EN enables the E0 extended-prefix states.
package scan_code_pkg;

    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;
    localparam logic [7:0] SC_ERR0 = 8'h00;
    localparam logic [7:0] SC_ERR1 = 8'hFF;

`ifdef SCAN_CODE_EXT_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXT    = 2'd1,
        BRK    = 2'd2,
        EXTBRK = 2'd3
    } sc_state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        BRK  = 1'b1
    } sc_state_t;
`endif

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } sc_event_t;

    function automatic logic is_err(input logic [7:0] b);
        return (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/sc_event_fifo.sv
// Key-event FIFO with a registered head, valid and full flag.
// Macro SCAN_CODE_EXT_EN does not affect this block.
module sc_event_fifo
    import scan_code_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  sc_event_t din,
    input  logic      pop,
    output sc_event_t dout,
    output logic      valid,
    output logic      empty,
    output logic      full,
    output logic      dropped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    sc_event_t        mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count;

    logic             do_pop;
    logic             do_push;
    logic [AW-1:0]    rd_next;
    logic [CW-1:0]    count_next;
    sc_event_t        head_next;

    always_comb begin
        do_pop     = pop && (count != '0);
        do_push    = push && ((count != DEPTH_C) || do_pop);
        dropped    = push && !do_push;
        rd_next    = do_pop ? rd_ptr + AW'(1) : rd_ptr;
        count_next = count + CW'(do_push) - CW'(do_pop);
        head_next  = '0;
        // A lone surviving entry that is being written now bypasses mem.
        if (count_next == CW'(1) && do_push)
            head_next = din;
        else if (count_next != '0)
            head_next = mem[rd_next];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            dout   <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_next;
            count  <= count_next;
            dout   <= head_next;
            valid  <= count_next != '0;
            full   <= count_next == DEPTH_C;
        end
    end

    assign empty = !valid;

endmodule

// File: rtl/scan_code_sequencer.sv
// Turns PS/2 set-2 scan bytes into make/break key events.
// Macro SCAN_CODE_EXT_EN enables E0 extended-key handling.
module scan_code_sequencer
    import scan_code_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] ScanCode,
    input  logic       NewCode,
    output logic [7:0] EvtData,
    output logic       EvtBreak,
    output logic       EvtExt,
    output logic       EvtValid,
    input  logic       EvtReady,
    output logic       Overflow,
    output logic       Busy
);

    sc_state_t state;
    sc_state_t state_next;
    sc_event_t evt;
    sc_event_t head;
    logic      push;
    logic      dropped;
    logic      fifo_empty;
    logic      fifo_full;

    always_comb begin
        state_next = state;
        push       = 1'b0;
        evt        = '0;
        evt.code   = ScanCode;
        if (NewCode) begin
            unique case (1'b1)
                is_err(ScanCode): state_next = IDLE;
`ifdef SCAN_CODE_EXT_EN
                (ScanCode == SC_EXT): begin
                    if (state == IDLE)
                        state_next = EXT;
                end
                (ScanCode == SC_BRK): begin
                    if (state == IDLE)
                        state_next = BRK;
                    else if (state == EXT)
                        state_next = EXTBRK;
                end
                default: begin
                    push       = 1'b1;
                    evt.brk    = (state == BRK) || (state == EXTBRK);
                    evt.ext    = (state == EXT) || (state == EXTBRK);
                    state_next = IDLE;
                end
`else
                // Without extended support E0 behaves like an error byte.
                (ScanCode == SC_EXT): state_next = IDLE;
                (ScanCode == SC_BRK): begin
                    if (state == IDLE)
                        state_next = BRK;
                end
                default: begin
                    push       = 1'b1;
                    evt.brk    = (state == BRK);
                    state_next = IDLE;
                end
`endif
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= IDLE;
            Busy     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state <= state_next;
            Busy  <= state_next != IDLE;
            if (dropped)
                Overflow <= 1'b1;
        end
    end

    sc_event_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (Clk),
        .rst_n  (Reset),
        .push   (push),
        .din    (evt),
        .pop    (EvtReady),
        .dout   (head),
        .valid  (EvtValid),
        .empty  (fifo_empty),
        .full   (fifo_full),
        .dropped(dropped)
    );

    assign EvtData  = head.code;
    assign EvtBreak = head.brk;
`ifdef SCAN_CODE_EXT_EN
    assign EvtExt   = head.ext;
    logic unused_flags;
    assign unused_flags = fifo_empty ^ fifo_full;
`else
    assign EvtExt   = 1'b0;
    logic unused_flags;
    assign unused_flags = fifo_empty ^ fifo_full ^ head.ext;
`endif

endmodule

// File: tb/tb_scan_code_sequencer.sv
// Directed self-checking bench for scan_code_sequencer (depth 4).
// Expectations follow SCAN_CODE_EXT_EN if the build defines it.
module tb_scan_code_sequencer;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic [7:0] ScanCode = 8'h00;
    logic       NewCode = 1'b0;
    logic [7:0] EvtData;
    logic       EvtBreak;
    logic       EvtExt;
    logic       EvtValid;
    logic       EvtReady = 1'b0;
    logic       Overflow;
    logic       Busy;

    int tests = 0;
    int fails = 0;

`ifdef SCAN_CODE_EXT_EN
    localparam logic EXT_ON = 1'b1;
`else
    localparam logic EXT_ON = 1'b0;
`endif

    scan_code_sequencer #(.FIFO_DEPTH(4)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .ScanCode(ScanCode),
        .NewCode (NewCode),
        .EvtData (EvtData),
        .EvtBreak(EvtBreak),
        .EvtExt  (EvtExt),
        .EvtValid(EvtValid),
        .EvtReady(EvtReady),
        .Overflow(Overflow),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic send(input logic [7:0] c);
        @(negedge Clk);
        ScanCode = c;
        NewCode  = 1'b1;
        @(negedge Clk);
        NewCode  = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge Clk);
        EvtReady = 1'b1;
        @(negedge Clk);
        EvtReady = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({EvtValid, Overflow, Busy, EvtData, EvtBreak, EvtExt} !== 13'h0) begin
            fails++;
            $display("FAIL reset_state: got v=%b o=%b b=%b d=%h br=%b e=%b want all 0",
                     EvtValid, Overflow, Busy, EvtData, EvtBreak, EvtExt);
        end
    endtask

    task automatic test_make();
        send(8'h1C);
        tests++;
        if ({EvtValid, EvtData, EvtBreak, EvtExt, Busy} !== {1'b1, 8'h1C, 3'b000}) begin
            fails++;
            $display("FAIL make_1c: got v=%b d=%h br=%b e=%b busy=%b want 1 1c 0 0 0",
                     EvtValid, EvtData, EvtBreak, EvtExt, Busy);
        end
        pop_one();
        tests++;
        if (EvtValid !== 1'b0) begin
            fails++;
            $display("FAIL make_pop: got valid=%b want 0", EvtValid);
        end
    endtask

    task automatic test_ext_break();
        send(8'hE0);
        tests++;
        if (Busy !== EXT_ON) begin
            fails++;
            $display("FAIL busy_after_e0: got %b want %b", Busy, EXT_ON);
        end
        send(8'hF0);
        tests++;
        if (Busy !== 1'b1 || EvtValid !== 1'b0) begin
            fails++;
            $display("FAIL busy_after_f0: got busy=%b valid=%b want 1 0", Busy, EvtValid);
        end
        send(8'h75);
        tests++;
        if ({EvtValid, EvtData, EvtBreak, EvtExt, Busy} !== {1'b1, 8'h75, 1'b1, EXT_ON, 1'b0}) begin
            fails++;
            $display("FAIL ext_break_75: got v=%b d=%h br=%b e=%b busy=%b want 1 75 1 %b 0",
                     EvtValid, EvtData, EvtBreak, EvtExt, Busy, EXT_ON);
        end
        pop_one();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send(codes[i]);
        tests++;
        if (Overflow !== 1'b1 || EvtData !== 8'h11) begin
            fails++;
            $display("FAIL overflow_set: got ovf=%b head=%h want 1 11", Overflow, EvtData);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (EvtValid !== 1'b1 || EvtData !== codes[i]) begin
                fails++;
                $display("FAIL overflow_order%0d: got v=%b d=%h want 1 %h",
                         i, EvtValid, EvtData, codes[i]);
            end
            pop_one();
        end
        tests++;
        if (EvtValid !== 1'b0 || Overflow !== 1'b1) begin
            fails++;
            $display("FAIL overflow_drained: got v=%b ovf=%b want 0 1", EvtValid, Overflow);
        end
        do_reset();
        tests++;
        if (Overflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_clear: got %b want 0", Overflow);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [4] = '{8'h22, 8'h33, 8'h44, 8'h2A};
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        @(negedge Clk);
        ScanCode = 8'h2A;
        NewCode  = 1'b1;
        EvtReady = 1'b1;
        @(negedge Clk);
        NewCode  = 1'b0;
        EvtReady = 1'b0;
        tests++;
        if (Overflow !== 1'b0 || EvtData !== 8'h22) begin
            fails++;
            $display("FAIL full_push_pop: got ovf=%b head=%h want 0 22", Overflow, EvtData);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (EvtValid !== 1'b1 || EvtData !== exp[i]) begin
                fails++;
                $display("FAIL full_order%0d: got v=%b d=%h want 1 %h",
                         i, EvtValid, EvtData, exp[i]);
            end
            pop_one();
        end
        tests++;
        if (EvtValid !== 1'b0 || Overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_drained: got v=%b ovf=%b want 0 0", EvtValid, Overflow);
        end
    endtask

    task automatic test_error_byte();
        send(8'hF0);
        send(8'hFF);
        tests++;
        if (EvtValid !== 1'b0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL err_ff: got v=%b busy=%b want 0 0", EvtValid, Busy);
        end
        send(8'h1C);
        tests++;
        if ({EvtValid, EvtData, EvtBreak} !== {1'b1, 8'h1C, 1'b0}) begin
            fails++;
            $display("FAIL err_then_make: got v=%b d=%h br=%b want 1 1c 0",
                     EvtValid, EvtData, EvtBreak);
        end
        pop_one();
    endtask

    task automatic test_reset_mid();
        send(8'hE0);
        send(8'hF0);
        @(negedge Clk);
        Reset    = 1'b0;
        ScanCode = 8'h1C;
        NewCode  = 1'b1;
        @(negedge Clk);
        Reset    = 1'b1;
        NewCode  = 1'b0;
        tests++;
        if (EvtValid !== 1'b0 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid: got v=%b busy=%b want 0 0", EvtValid, Busy);
        end
        send(8'h1C);
        tests++;
        if ({EvtValid, EvtData, EvtBreak, EvtExt} !== {1'b1, 8'h1C, 2'b00}) begin
            fails++;
            $display("FAIL reset_mid_make: got v=%b d=%h br=%b e=%b want 1 1c 0 0",
                     EvtValid, EvtData, EvtBreak, EvtExt);
        end
        pop_one();
    endtask

    task automatic test_back_to_back();
        @(negedge Clk);
        EvtReady = 1'b1;
        ScanCode = 8'h1C;
        NewCode  = 1'b1;
        @(negedge Clk);
        EvtReady = 1'b0;
        ScanCode = 8'h32;
        @(negedge Clk);
        NewCode  = 1'b0;
        tests++;
        if (EvtValid !== 1'b1 || EvtData !== 8'h1C) begin
            fails++;
            $display("FAIL b2b_head: got v=%b d=%h want 1 1c", EvtValid, EvtData);
        end
        pop_one();
        tests++;
        if (EvtValid !== 1'b1 || EvtData !== 8'h32) begin
            fails++;
            $display("FAIL b2b_second: got v=%b d=%h want 1 32", EvtValid, EvtData);
        end
        pop_one();
        tests++;
        if (EvtValid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_empty: got v=%b want 0", EvtValid);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_overflow();
        test_full_push_pop();
        test_error_byte();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/scan_code_sequencer.md
SCAN_CODE_SEQUENCER -- requirements
Module: scan_code_sequencer

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, key-event FIFO entries; SHALL be a power of two, range 2..16.
REQ-002 Clk  input  1  system clock; all sequential logic SHALL update on the rising edge.
REQ-003 Reset  input  1  synchronous, active-low reset; SHALL be sampled on the rising edge of Clk.
REQ-004 ScanCode  input  8  received scan-code byte; valid only while NewCode=1.
REQ-005 NewCode  input  1  one-cycle strobe, parity-checked byte present on ScanCode.
REQ-006 EvtData  output  8  key code of the FIFO head event.
REQ-007 EvtBreak  output  1  head event is a release (break); 0 = press (make).
REQ-008 EvtExt  output  1  head event carried the E0 extended prefix.
REQ-009 EvtValid  output  1  FIFO non-empty; head fields valid.
REQ-010 EvtReady  input  1  consumer accepts the head event when EvtValid=1.
REQ-011 Overflow  output  1  sticky flag, one or more events dropped because the FIFO was full.
REQ-012 Busy  output  1  prefix FSM not in IDLE, i.e. a multi-byte sequence is in progress.

Function
REQ-013 Prefix FSM states SHALL be: IDLE, EXT (E0 seen), BRK (F0 seen), EXTBRK (E0 then F0 seen).
REQ-014 Transitions SHALL occur only in cycles with NewCode=1; in all other cycles the state SHALL hold.
REQ-015 On ScanCode=8'hE0: IDLE->EXT; the byte SHALL be ignored (state unchanged) in EXT, BRK and EXTBRK.
REQ-016 On ScanCode=8'hF0: IDLE->BRK, EXT->EXTBRK; the byte SHALL be ignored in BRK and EXTBRK.
REQ-017 On ScanCode=8'h00 or 8'hFF (keyboard error): the FSM SHALL return to IDLE and no event SHALL be pushed.
REQ-018 On any other byte: the FSM SHALL push {code, Break=(state in BRK|EXTBRK), Ext=(state in EXT|EXTBRK)} and return to IDLE.
REQ-019 A pushed event SHALL appear on EvtValid/EvtData on the first rising edge after the NewCode cycle when the FIFO was empty (latency 1).
REQ-020 A pop SHALL occur on a rising edge where EvtValid=1 and EvtReady=1; EvtReady with an empty FIFO SHALL have no effect.
REQ-021 A push while full SHALL be accepted only if a pop occurs in the same cycle; otherwise the event SHALL be dropped and Overflow set.
REQ-022 A simultaneous push and pop on a non-full, non-empty FIFO SHALL leave the occupancy unchanged and preserve order.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL use log2(FIFO_DEPTH)+1 bits.
REQ-024 Overflow SHALL remain 1 until reset.

Reset
REQ-025 With Reset=0 at a rising edge: FSM->IDLE, FIFO emptied, EvtValid=0, Overflow=0, Busy=0; EvtData, EvtBreak and EvtExt SHALL be 0.
REQ-026 Reset in mid-sequence (Busy=1) SHALL discard the partial prefix; NewCode in the reset cycle SHALL be ignored.

Configuration
REQ-027 Macro SCAN_CODE_EXT_EN: when defined, E0 handling follows REQ-015/016/018.
REQ-028 Without SCAN_CODE_EXT_EN: EXT and EXTBRK SHALL NOT exist, 8'hE0 SHALL be discarded like an error byte while IDLE is retained, and EvtExt SHALL be tied to 0.

Structure
REQ-029 Shared package scan_code_pkg SHALL hold the FSM state enum, the constants SC_EXT=8'hE0, SC_BRK=8'hF0, SC_ERR0=8'h00 and SC_ERR1=8'hFF, and the 10-bit event struct {ext, brk, code}.
REQ-030 The FIFO SHALL be the sub-module sc_event_fifo (parameterised depth, push/pop/full/empty, registered outputs); the prefix FSM SHALL reside in scan_code_sequencer.

Verification
REQ-031 NewCode with 8'h1C, EvtReady=0 -> next cycle EvtValid=1, EvtData=8'h1C, EvtBreak=0, EvtExt=0, Busy=0.
REQ-032 Sequence E0, F0, 75 -> Busy=1 after E0 and after F0; one event {75, Break=1, Ext=1}; with the macro undefined -> {75, Break=1, Ext=0}.
REQ-033 Push 5 distinct codes with EvtReady=0 and depth 4 -> first 4 retained in order, 5th dropped, Overflow=1 until reset.
REQ-034 FIFO full, push 8'h2A with EvtReady=1 in the same cycle -> head popped, 8'h2A accepted at the tail, Overflow stays 0.
REQ-035 Sequence F0 then FF -> no event, FSM in IDLE, Busy=0; a following 8'h1C -> make event.
REQ-036 E0 then Reset=0 for one cycle, then 8'h1C -> FIFO empty after reset, then event {1C, Break=0, Ext=0}.
